alu_result_fifo: RTL and testbench
==================================

# alu_result_fifo

Downstream capture stage for the 4-bit ALU. It samples the ALU's 8-bit result bus (result, carry, zero) under a valid/ready handshake and buffers the entries in a small synchronous FIFO. The consumer (output mux or host readback logic) drains the FIFO at its own pace. Optional statistics counters track carry and zero events across the accepted stream.

## Interface
- `DEPTH`, default 4: FIFO entries; power of two, 2..16.
- `CNT_W`, default 8: width of the statistics counters.
- `clk` input, 1: single clock; all state updates on the rising edge.
- `rst_n` input, 1: asynchronous, active-low reset.
- `in_data` input, 8: ALU output bus; [3:0] result, [4] carry, [5] zero, [7:6] ignored.
- `in_valid` input, 1: producer presents `in_data`.
- `in_ready` output, 1: FIFO can accept; `= (count != DEPTH)`.
- `out_data` output, 6: head entry {zero, carry, result[3:0]}; 0 when empty.
- `out_valid` output, 1: FIFO not empty.
- `out_ready` input, 1: consumer pops the head this cycle.
- `clear` input, 1: synchronous flush of FIFO, counters and sticky flag.
- `count` output, $clog2(DEPTH)+1: current occupancy.
- `overflow` output, 1: sticky; set when `in_valid && !in_ready`.
- `carry_cnt` output, CNT_W: accepted entries with carry=1 (stats build only).
- `zero_cnt` output, CNT_W: accepted entries with zero=1 (stats build only).

## Operation
- Push: `push = in_valid && in_ready`. Writes `in_data[5:0]` at `wr_ptr`; `wr_ptr` increments modulo DEPTH.
- Pop: `pop = out_valid && out_ready`. `rd_ptr` increments modulo DEPTH.
- `count` next = count + push − pop. Push and pop in the same cycle leave it unchanged.
- When full, `in_ready` = 0, even if a pop happens in the same cycle. There is no pass-through on full.
- When empty, a pop request is ignored. `out_valid` = 0 and `out_data` = 0.
- Pointers carry a wrap bit. Full is pointers equal with wrap bits differing; empty is pointers fully equal.
- `overflow` is set on any cycle with `in_valid && !in_ready`. It stays set until `clear` or reset. The dropped data is discarded.
- `clear` has priority over push and pop in the same cycle. It sets pointers, `count`, `overflow` and the counters to 0. Memory contents are don't-care.
- Statistics counters:
  - Increment on push when the corresponding bit is 1.
  - Saturate at 2^CNT_W − 1 and do not wrap.

## Timing
- Reset: all of the following are 0 while `rst_n` = 0 and after release: `count`, pointers, `overflow`, `carry_cnt`, `zero_cnt`, `out_valid`, `out_data`.
- `in_ready` = 1 out of reset.
- Reset asserted mid-stream discards all entries immediately (asynchronous).
- Latency: data pushed at edge N appears on `out_data` with `out_valid` = 1 after edge N. It is visible the cycle after the push.
- `out_data` is read combinationally from memory at `rd_ptr` and is valid whenever `out_valid` = 1.
- `in_ready` and `out_valid` depend only on registered state. There is no combinational path from `in_valid` or `out_ready` to them.
- `overflow` is visible the cycle after the dropped attempt.
- Counters update on the same edge as the push.

## Configuration
- Macro `ALU_FIFO_STATS_EN`.
- Defined: `carry_cnt` and `zero_cnt` are implemented as described.
- Undefined:
  - Both ports remain and are tied to 0.
  - No counter flops are generated.
  - FIFO and `overflow` behaviour is identical to the defined build.

## Test plan
- Reset then idle → `count` = 0, `in_ready` = 1, `out_valid` = 0, `out_data` = 0, `overflow` = 0.
- Push 0x15 (result 5, carry 1) → next cycle `out_data` = 0x15, `out_valid` = 1, `count` = 1, `carry_cnt` = 1; pop → `count` = 0.
- Push 4 entries with `out_ready` = 0 → `in_ready` = 0. A 5th push attempt sets `overflow` = 1, and `count` stays 4. Draining returns the entries in order.
- Full FIFO with `in_valid` = 1 and `out_ready` = 1 → the pop occurs and the push is refused that cycle (`overflow` set). The next cycle `in_ready` = 1.
- Continuous push+pop of 20 entries including 0x20 (zero) → `count` stays 1, pointers wrap, data ordering is correct, `zero_cnt` matches the number of zero entries.
- Assert `clear` together with a push at `count` = 3 → `count` = 0, counters = 0, `overflow` = 0; assert `rst_n` = 0 mid-drain → all outputs 0 immediately.

Source files
------------

// File: rtl/alu_result_fifo.sv
// Capture FIFO behind the 4-bit ALU: buffers {zero, carry, result} entries.
// Define ALU_FIFO_STATS_EN to build the saturating carry/zero event counters.
module alu_result_fifo #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [5:0]             out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    input  logic                   clear,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic [CNT_W-1:0]       carry_cnt,
    output logic [CNT_W-1:0]       zero_cnt
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic [5:0]    r_mem [DEPTH];
    logic          r_overflow;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_unused;

    assign w_unused = ^in_data[7:6];

    // Wrap bit distinguishes full from empty when the indices match
    assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                     (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign w_empty = (r_wr_ptr == r_rd_ptr);

    assign in_ready  = !w_full;
    assign out_valid = !w_empty;
    assign w_push    = in_valid && !w_full;
    assign w_pop     = out_ready && !w_empty;

    assign count     = r_wr_ptr - r_rd_ptr;
    assign overflow  = r_overflow;
    assign out_data  = w_empty ? 6'd0 : r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= in_data[5:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else if (clear) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (in_valid && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

`ifdef ALU_FIFO_STATS_EN
    logic [CNT_W-1:0] r_carry_cnt;
    logic [CNT_W-1:0] r_zero_cnt;

    // Counters stick at all-ones rather than wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_carry_cnt <= '0;
            r_zero_cnt  <= '0;
        end else if (clear) begin
            r_carry_cnt <= '0;
            r_zero_cnt  <= '0;
        end else if (w_push) begin
            if (in_data[4] && (r_carry_cnt != '1)) begin
                r_carry_cnt <= r_carry_cnt + 1'b1;
            end
            if (in_data[5] && (r_zero_cnt != '1)) begin
                r_zero_cnt <= r_zero_cnt + 1'b1;
            end
        end
    end

    assign carry_cnt = r_carry_cnt;
    assign zero_cnt  = r_zero_cnt;
`else
    assign carry_cnt = '0;
    assign zero_cnt  = '0;
`endif

endmodule

// File: tb/tb_alu_result_fifo.sv
// Scoreboard bench for alu_result_fifo against a queue-based reference.
module tb_alu_result_fifo;

    localparam int DEPTH = 4;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [7:0]             in_data = '0;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [5:0]             out_data;
    logic                   out_valid;
    logic                   out_ready = 1'b0;
    logic                   clear = 1'b0;
    logic [$clog2(DEPTH):0] count;
    logic                   overflow;
    logic [CNT_W-1:0]       carry_cnt;
    logic [CNT_W-1:0]       zero_cnt;

    alu_result_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .clear(clear), .count(count), .overflow(overflow),
        .carry_cnt(carry_cnt), .zero_cnt(zero_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    logic [5:0] model_q[$];
    logic [5:0] exp_q[$];
    bit         m_ovf = 0;
    int         m_c = 0;
    int         m_z = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic int exp_cnt(input int v);
`ifdef ALU_FIFO_STATS_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    task automatic check_state(input string tag);
        chk({tag, ".count"}, 32'(count), 32'(model_q.size()));
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(model_q.size() != DEPTH));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(model_q.size() != 0));
        chk({tag, ".out_data"}, 32'(out_data),
            model_q.size() != 0 ? 32'(model_q[0]) : 32'd0);
        chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
        chk({tag, ".carry_cnt"}, 32'(carry_cnt), 32'(exp_cnt(m_c)));
        chk({tag, ".zero_cnt"}, 32'(zero_cnt), 32'(exp_cnt(m_z)));
    endtask

    task automatic model_reset();
        model_q.delete();
        exp_q.delete();
        m_ovf = 0;
        m_c = 0;
        m_z = 0;
    endtask

    // One clock of stimulus; the reference is updated from the rules directly
    task automatic step(input bit iv, input logic [7:0] d, input bit ordy,
                        input bit clr, input string tag);
        bit full, pu, po;
        @(negedge clk);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        clear     = clr;
        full = (model_q.size() == DEPTH);
        pu = iv && !full;
        po = ordy && (model_q.size() != 0);
        @(posedge clk);
        if (clr) begin
            model_reset();
        end else begin
            if (iv && full) m_ovf = 1;
            if (po) void'(model_q.pop_front());
            if (pu) begin
                model_q.push_back(d[5:0]);
                exp_q.push_back(d[5:0]);
                if (d[4] && m_c < CMAX) m_c++;
                if (d[5] && m_z < CMAX) m_z++;
            end
        end
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        clear     = 1'b0;
        check_state(tag);
    endtask

    // Monitor: consumes expected entries whenever the DUT hands one out
    initial begin
        logic [5:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && !clear && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL mon_pop: got 0x%0h expected no entry",
                             out_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("mon_pop", 32'(out_data), 32'(e));
                end
            end
        end
    end

    initial begin
        #12;
        check_state("in_reset");
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 8'h00, 0, 0, "idle");

        step(1, 8'hD5, 0, 0, "push15");
        step(0, 8'h00, 1, 0, "pop15");

        for (int i = 0; i < DEPTH; i++)
            step(1, 8'(8'h01 + 8'(i) * 8'h11), 0, 0, "fill");
        step(1, 8'h3F, 0, 0, "ovf_attempt");
        for (int i = 0; i < DEPTH; i++)
            step(0, 8'h00, 1, 0, "drain");

        step(0, 8'h00, 0, 1, "clr1");
        for (int i = 0; i < DEPTH; i++)
            step(1, 8'(8'h10 + 8'(i)), 0, 0, "fill2");
        step(1, 8'h2A, 1, 0, "full_pushpop");
        step(0, 8'h00, 0, 0, "after_full");
        for (int i = 0; i < DEPTH - 1; i++)
            step(0, 8'h00, 1, 0, "drain2");

        step(1, 8'h01, 0, 0, "stream_prime");
        for (int i = 0; i < 20; i++)
            step(1, (i % 3 == 0) ? 8'h20 : 8'($urandom_range(0, 255)), 1, 0,
                 "stream");
        step(0, 8'h00, 1, 0, "stream_end");

        for (int i = 0; i < 3; i++)
            step(1, 8'h30, 0, 0, "pre_clr");
        step(1, 8'h15, 0, 1, "clr_push");

        for (int i = 0; i < DEPTH; i++)
            step(1, 8'h35, 0, 0, "pre_rst");
        step(1, 8'h07, 1, 0, "pre_rst_ovf");
        step(0, 8'h00, 1, 0, "drain_rst");
        @(negedge clk);
        out_ready = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        out_ready = 1'b0;
        check_state("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 8'h00, 0, 0, "post_rst");

        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 2) != 0), $urandom_range(0, 49) == 0,
                 "rand");
        for (int i = 0; i < DEPTH; i++)
            step(0, 8'h00, 1, 0, "final_drain");
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
